sreg_frame: RTL and testbench

Parametrised serial-to-parallel / parallel-to-serial framing register for the CPLD host link. It shifts DWIDTH-bit words in from the host's serial line, in either bit order. Each completed word is latched into a holding register with a valid/ack handshake and overrun detection. A parallel word can be loaded for serial readback. It sits between the serial pins and the address/data decode logic, replacing the plain 21-bit shift register.

---
 rtl/sreg_frame_pkg.sv | 18 +
 rtl/sreg_frame_if.sv | 37 +++
 rtl/sreg_frame_bitcnt.sv | 50 +++++
 rtl/sreg_frame.sv | 110 +++++++++++
 tb/tb_sreg_frame.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sreg_frame_pkg.sv
// -----------------------------------------------------------------------------
// sreg_frame_pkg
// Shared definitions for the serial framing register:
//   ORDER_MSB_FIRST / ORDER_LSB_FIRST - values for the MSB_FIRST parameter
//   cnt_width()                       - bit counter width for a word length
// -----------------------------------------------------------------------------
package sreg_frame_pkg;

  localparam bit ORDER_MSB_FIRST = 1'b1;  // first received bit lands in out[DWIDTH-1]
  localparam bit ORDER_LSB_FIRST = 1'b0;  // first received bit lands in out[0]

  // Counter only has to reach DWIDTH-1, so $clog2(DWIDTH) bits suffice.
  // A 1-bit floor keeps the declaration legal for degenerate widths.
  function automatic int cnt_width(input int dwidth);
    return (dwidth > 1) ? $clog2(dwidth) : 1;
  endfunction

endpackage

// File: rtl/sreg_frame_if.sv
// -----------------------------------------------------------------------------
// sreg_frame_if
// Host-link signal bundle for sreg_frame.
//   master: drives in, en (active-low frame select), load, din, ack;
//           observes sout, out, valid, overrun, bitcnt, debug
//   slave : the framing register itself (directions mirrored)
// -----------------------------------------------------------------------------
interface sreg_frame_if
  import sreg_frame_pkg::*;
#(
  parameter int DWIDTH = 21,
  parameter int CW     = cnt_width(DWIDTH)
);

  logic              in;
  logic              en;
  logic              load;
  logic [DWIDTH-1:0] din;
  logic              ack;
  logic              sout;
  logic [DWIDTH-1:0] out;
  logic              valid;
  logic              overrun;
  logic [CW-1:0]     bitcnt;
  logic [3:0]        debug;

  modport master (
    output in, en, load, din, ack,
    input  sout, out, valid, overrun, bitcnt, debug
  );

  modport slave (
    input  in, en, load, din, ack,
    output sout, out, valid, overrun, bitcnt, debug
  );

endinterface

// File: rtl/sreg_frame_bitcnt.sv
// -----------------------------------------------------------------------------
// sreg_bitcnt
// Modulo-DWIDTH bit counter for the framing register.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : synchronous clear (frame deselected), wins over inc_i
//   inc_i    : count one received bit
//   cnt_o    : bits received in the current word, 0..DWIDTH-1
//   tc_o     : counter sits at DWIDTH-1; the next increment completes a word
// -----------------------------------------------------------------------------
module sreg_bitcnt
  import sreg_frame_pkg::*;
#(
  parameter int DWIDTH = 21,
  parameter int CW     = cnt_width(DWIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == CW'(DWIDTH - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      // Wrap straight from DWIDTH-1 to 0 so back-to-back words need no gap cycle.
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: reset sits in the sensitivity list so it acts immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sreg_frame.sv
// -----------------------------------------------------------------------------
// sreg_frame
// Serial-to-parallel / parallel-to-serial framing register for the CPLD host
// link. Shifts DWIDTH-bit words in while en is low, latches each completed word
// into a holding register with a valid/ack handshake and sticky overrun, and
// lets a parallel word be loaded (en high) for serial readback on sout.
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : in, en, load, din, ack -> sout, out, valid, overrun,
//                  bitcnt, debug
// Parameters: DWIDTH word length (2..32), MSB_FIRST bit order.
// -----------------------------------------------------------------------------
module sreg_frame
  import sreg_frame_pkg::*;
#(
  parameter  int DWIDTH    = 21,
  parameter  bit MSB_FIRST = ORDER_MSB_FIRST,
  localparam int CW        = cnt_width(DWIDTH)
) (
  input logic         clk,
  input logic         rst,
  sreg_frame_if.slave bus
);

  logic [DWIDTH-1:0] buf_q, buf_d;
  logic [DWIDTH-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [DWIDTH-1:0] shifted;   // buffer value after this cycle's shift
  logic              shift;
  logic              tc;
  logic              complete;

  assign shift    = ~bus.en;
  assign complete = shift & tc;

  sreg_bitcnt #(
    .DWIDTH (DWIDTH),
    .CW     (CW)
  ) u_bitcnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (bus.en),
    .inc_i (shift),
    .cnt_o (bus.bitcnt),
    .tc_o  (tc)
  );

  // The outgoing bit is the one that falls off the far end of the buffer, so
  // readback and reception share the same shift.
  if (MSB_FIRST) begin : g_msb_first
    assign shifted  = {buf_q[DWIDTH-2:0], bus.in};
    assign bus.sout = buf_q[DWIDTH-1];
  end else begin : g_lsb_first
    assign shifted  = {bus.in, buf_q[DWIDTH-1:1]};
    assign bus.sout = buf_q[0];
  end

  if (DWIDTH >= 4) begin : g_debug_full
    assign bus.debug = buf_q[3:0];
  end else begin : g_debug_narrow
    assign bus.debug = {{(4 - DWIDTH){1'b0}}, buf_q};
  end

  always_comb begin
    buf_d     = buf_q;
    out_d     = out_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (bus.en) begin
      if (bus.load) begin
        buf_d = bus.din;
      end
    end else begin
      buf_d = shifted;
    end

    if (complete) begin
      // Newest word always wins. An ack in the completion cycle belongs to
      // the old word, so valid stays set and overrun is left alone.
      out_d   = shifted;
      valid_d = 1'b1;
      if (valid_q && !bus.ack) begin
        overrun_d = 1'b1;
      end
    end else if (bus.ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q     <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_sreg_frame.sv
// -----------------------------------------------------------------------------
// tb_sreg_frame
// Drives two sreg_frame instances (MSB-first and LSB-first, DWIDTH=21) with
// identical stimulus and compares both against a word-level reference model:
// a table of whole words, directed multi-cycle sequences, then random traffic.
// -----------------------------------------------------------------------------
module tb_sreg_frame;

  localparam int DW = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_s, en_s, load_s, ack_s;
  logic [DW-1:0] din_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sreg_frame_if #(.DWIDTH(DW)) if_m ();
  sreg_frame_if #(.DWIDTH(DW)) if_l ();

  assign if_m.in   = in_s;
  assign if_m.en   = en_s;
  assign if_m.load = load_s;
  assign if_m.din  = din_s;
  assign if_m.ack  = ack_s;
  assign if_l.in   = in_s;
  assign if_l.en   = en_s;
  assign if_l.load = load_s;
  assign if_l.din  = din_s;
  assign if_l.ack  = ack_s;

  sreg_frame #(.DWIDTH(DW), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(if_m));
  sreg_frame #(.DWIDTH(DW), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(if_l));

  // ---------------- reference model ----------------
  // Received bits of the current frame are kept as a list; words are built
  // from that list. The readback buffer is modelled as plain integer shifts.
  logic [DW-1:0] m_buf_m, m_buf_l, m_out_m, m_out_l;
  logic          m_valid, m_ovr;
  bit            m_bits[$];

  task automatic model_reset();
    m_buf_m = '0;
    m_buf_l = '0;
    m_out_m = '0;
    m_out_l = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_bits.delete();
  endtask

  task automatic model_edge();
    logic [DW-1:0] w_m, w_l;
    if (rst) begin
      model_reset();
    end else if (en_s) begin
      m_bits.delete();
      if (load_s) begin
        m_buf_m = din_s;
        m_buf_l = din_s;
      end
      if (ack_s) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end else begin
      m_buf_m = (m_buf_m << 1) | DW'(in_s);
      m_buf_l = (m_buf_l >> 1) | (DW'(in_s) << (DW - 1));
      m_bits.push_back(in_s);
      if (m_bits.size() == DW) begin
        w_m = '0;
        w_l = '0;
        for (int i = 0; i < DW; i++) begin
          w_m[DW-1-i] = m_bits[i];
          w_l[i]      = m_bits[i];
        end
        m_out_m = w_m;
        m_out_l = w_l;
        if (m_valid && !ack_s) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_bits.delete();
      end else if (ack_s) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = m_bits.size();
    check("out_m",   32'(if_m.out),     32'(m_out_m));
    check("out_l",   32'(if_l.out),     32'(m_out_l));
    check("valid_m", 32'(if_m.valid),   32'(m_valid));
    check("valid_l", 32'(if_l.valid),   32'(m_valid));
    check("ovr_m",   32'(if_m.overrun), 32'(m_ovr));
    check("ovr_l",   32'(if_l.overrun), 32'(m_ovr));
    check("cnt_m",   32'(if_m.bitcnt),  32'(n));
    check("cnt_l",   32'(if_l.bitcnt),  32'(n));
    check("sout_m",  32'(if_m.sout),    32'(m_buf_m[DW-1]));
    check("sout_l",  32'(if_l.sout),    32'(m_buf_l[0]));
    check("dbg_m",   32'(if_m.debug),   32'(m_buf_m[3:0]));
    check("dbg_l",   32'(if_l.debug),   32'(m_buf_l[3:0]));
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare.
  task automatic cycle(input logic i_in, input logic i_en, input logic i_load,
                       input logic [DW-1:0] i_din, input logic i_ack);
    in_s   = i_in;
    en_s   = i_en;
    load_s = i_load;
    din_s  = i_din;
    ack_s  = i_ack;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Stream one word, earliest bit = word[DW-1]; optional ack on the last bit.
  task automatic stream_word(input logic [DW-1:0] word, input logic ack_last);
    for (int i = DW - 1; i >= 0; i--) begin
      cycle(word[i], 1'b0, 1'b0, '0, (i == 0) ? ack_last : 1'b0);
    end
  endtask

  task automatic async_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
  endtask

  typedef struct {
    logic [DW-1:0] word;
    logic [DW-1:0] exp_m;
    logic [DW-1:0] exp_l;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{21'h1ABCDE, 21'h1ABCDE, 21'h0F67AB};
    vecs[1] = '{21'h000001, 21'h000001, 21'h100000};
    vecs[2] = '{21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF};
    vecs[3] = '{21'h155555, 21'h155555, 21'h155555};
    vecs[4] = '{21'h000003, 21'h000003, 21'h180000};
    vecs[5] = '{21'h0F0F0F, 21'h0F0F0F, 21'h1E1E1E};

    rst = 1'b1; in_s = 1'b0; en_s = 1'b1; load_s = 1'b0; din_s = '0; ack_s = 1'b0;
    model_reset();
    #2;
    check_all();
    check("rst_valid", 32'(if_m.valid), 32'd0);
    check("rst_out",   32'(if_m.out),   32'd0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);  // shifting held off by reset
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    rst = 1'b0;

    // Table of whole words, each acknowledged afterwards.
    for (int v = 0; v < 6; v++) begin
      stream_word(vecs[v].word, 1'b0);
      check("tbl_out_m", 32'(if_m.out),    32'(vecs[v].exp_m));
      check("tbl_out_l", 32'(if_l.out),    32'(vecs[v].exp_l));
      check("tbl_valid", 32'(if_m.valid),  32'd1);
      check("tbl_cnt",   32'(if_m.bitcnt), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
      check("tbl_ack",   32'(if_m.valid),  32'd0);
    end

    // Parallel load then readback while zeros shift in.
    cycle(1'b0, 1'b1, 1'b1, 21'h155555, 1'b0);
    check("ld_dbg_m", 32'(if_m.debug), 32'h5);
    check("ld_sout_l", 32'(if_l.sout), 32'd1);
    for (int k = 0; k < DW; k++) begin
      check("rb_sout_m", 32'(if_m.sout), (k % 2 == 0) ? 32'd1 : 32'd0);
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    end
    check("rb_out",   32'(if_m.out),   32'd0);
    check("rb_valid", 32'(if_m.valid), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
    // load while shifting is ignored
    cycle(1'b1, 1'b0, 1'b1, 21'h1FFFFF, 1'b0);
    check("ld_ign_dbg", 32'(if_m.debug), 32'h1);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);

    // Back-to-back words without ack -> overrun, newest word kept.
    stream_word(21'h123456, 1'b0);
    check("b2b_ovr0", 32'(if_m.overrun), 32'd0);
    stream_word(21'h0F0F0F, 1'b0);
    check("b2b_ovr1", 32'(if_m.overrun), 32'd1);
    check("b2b_out",  32'(if_m.out),     32'h0F0F0F);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
    check("b2b_ackv", 32'(if_m.valid),   32'd0);
    check("b2b_acko", 32'(if_m.overrun), 32'd0);

    // Ack on the completion edge of the second word.
    stream_word(21'h0AAAAA, 1'b0);
    stream_word(21'h1C3C3C, 1'b1);
    check("cack_valid", 32'(if_m.valid),   32'd1);
    check("cack_ovr",   32'(if_m.overrun), 32'd0);
    check("cack_out",   32'(if_m.out),     32'h1C3C3C);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);

    // Abort mid-word, then reset in the middle of the next frame.
    for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b0);
    check("mid_cnt", 32'(if_m.bitcnt), 32'd10);
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    check("abort_cnt",   32'(if_m.bitcnt), 32'd0);
    check("abort_valid", 32'(if_m.valid),  32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    async_reset();
    check("ar_cnt",  32'(if_m.bitcnt), 32'd0);
    check("ar_dbg",  32'(if_m.debug),  32'd0);
    check("ar_sout", 32'(if_l.sout),   32'd0);
    check("ar_out",  32'(if_m.out),    32'd0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    stream_word(21'h1ABCDE, 1'b0);
    check("post_rst_out", 32'(if_m.out),   32'h1ABCDE);
    check("post_rst_vld", 32'(if_m.valid), 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (rst) begin
        if ($urandom_range(0, 1) == 0) rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end
      cycle(1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            DW'($urandom),
            ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
